// File: rtl/eprisc_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : eprisc_bus_arbiter
//  Purpose  : Two-port round-robin arbiter for the shared ROM/RAM bus.
//             Port A (core) and port B (DMA/debug) each issue single
//             read/write transactions. A granted transaction runs through
//             IDLE -> SETUP -> (WAIT) -> ACK. Address bit 8 selects the
//             region: 0 = ROM, 1 = RAM. Writes to ROM are dropped, flagged
//             on oFault and still acknowledged.
//  Ports    : iClk, iRst                    clock, synchronous active-high reset
//             iReqX/iWriteX/iAddrX/iDataX   requester X (A or B) inputs
//             oAckX/oDataX                  completion pulse, read data
//             oMemAddr/oMemData/iMemData    shared bus address/data
//             oMemWrite/oRomEn/oRamEn       shared bus strobes
//             oFault                        illegal ROM write pulse
//             oBusy                         FSM not in IDLE
//  Revision : 1.0  initial release
// ============================================================================
module eprisc_bus_arbiter #(
  parameter int pWaitCycles = 1  // read latency in clocks, 1..15
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iReqA,
  input  logic        iWriteA,
  input  logic [31:0] iAddrA,
  input  logic [31:0] iDataA,
  output logic        oAckA,
  output logic [31:0] oDataA,
  input  logic        iReqB,
  input  logic        iWriteB,
  input  logic [31:0] iAddrB,
  input  logic [31:0] iDataB,
  output logic        oAckB,
  output logic [31:0] oDataB,
  output logic [31:0] oMemAddr,
  output logic [31:0] oMemData,
  input  logic [31:0] iMemData,
  output logic        oMemWrite,
  output logic        oRomEn,
  output logic        oRamEn,
  output logic        oFault,
  output logic        oBusy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SETUP = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_ACK   = 2'd3;

  localparam logic [3:0] cWaitLoad = 4'(pWaitCycles - 1);

  // Owner / last-served encoding: 0 = port A, 1 = port B
  logic [1:0]  state_q,    state_d;
  logic        owner_q,    owner_d;
  logic        last_q,     last_d;
  logic [31:0] reqAddr_q,  reqAddr_d;
  logic [31:0] reqData_q,  reqData_d;
  logic        reqWrite_q, reqWrite_d;
  logic [3:0]  cnt_q,      cnt_d;

  // Bus and port outputs are registered; their next values are computed
  // from the next state so they line up exactly with the state they belong to.
  logic [31:0] memAddr_q,  memAddr_d;
  logic [31:0] memData_q,  memData_d;
  logic        memWrite_q, memWrite_d;
  logic        romEn_q,    romEn_d;
  logic        ramEn_q,    ramEn_d;
  logic        fault_q,    fault_d;
  logic        ackA_q,     ackA_d;
  logic        ackB_q,     ackB_d;
  logic [31:0] dataA_q,    dataA_d;
  logic [31:0] dataB_q,    dataB_d;

  logic        grantB;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    reqAddr_d  = reqAddr_q;
    reqData_d  = reqData_q;
    reqWrite_d = reqWrite_q;
    cnt_d      = cnt_q;
    memAddr_d  = memAddr_q;
    memData_d  = memData_q;
    memWrite_d = 1'b0;
    romEn_d    = 1'b0;
    ramEn_d    = 1'b0;
    fault_d    = 1'b0;
    ackA_d     = 1'b0;
    ackB_d     = 1'b0;
    dataA_d    = dataA_q;
    dataB_d    = dataB_q;
    grantB     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (iReqA || iReqB) begin
          // B wins only if A is idle, or on a tie when A was served last
          grantB     = iReqB && (!iReqA || !last_q);
          owner_d    = grantB;
          reqAddr_d  = grantB ? iAddrB  : iAddrA;
          reqData_d  = grantB ? iDataB  : iDataA;
          reqWrite_d = grantB ? iWriteB : iWriteA;
          state_d    = S_SETUP;

          // Bus values for the SETUP cycle
          memAddr_d = reqAddr_d;
          memData_d = reqData_d;
          if (!reqWrite_d) begin
            romEn_d = !reqAddr_d[8];
            ramEn_d = reqAddr_d[8];
          end else if (reqAddr_d[8]) begin
            ramEn_d    = 1'b1;
            memWrite_d = 1'b1;
          end else begin
            fault_d = 1'b1;  // ROM write: dropped, but flagged
          end
        end
      end

      S_SETUP: begin
        if (reqWrite_q) begin
          state_d = S_ACK;
          ackA_d  = !owner_q;
          ackB_d  = owner_q;
        end else begin
          state_d = S_WAIT;
          cnt_d   = cWaitLoad;
          romEn_d = !reqAddr_q[8];
          ramEn_d = reqAddr_q[8];
        end
      end

      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          // Last WAIT cycle: memory data is valid now
          if (owner_q) dataB_d = iMemData;
          else         dataA_d = iMemData;
          state_d = S_ACK;
          ackA_d  = !owner_q;
          ackB_d  = owner_q;
        end else begin
          cnt_d   = cnt_q - 4'd1;
          romEn_d = !reqAddr_q[8];
          ramEn_d = reqAddr_q[8];
        end
      end

      S_ACK: begin
        last_d  = owner_q;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q    <= S_IDLE;
      owner_q    <= 1'b0;
      last_q     <= 1'b1;  // B counts as last served so A wins the first tie
      reqAddr_q  <= '0;
      reqData_q  <= '0;
      reqWrite_q <= 1'b0;
      cnt_q      <= '0;
      memAddr_q  <= '0;
      memData_q  <= '0;
      memWrite_q <= 1'b0;
      romEn_q    <= 1'b0;
      ramEn_q    <= 1'b0;
      fault_q    <= 1'b0;
      ackA_q     <= 1'b0;
      ackB_q     <= 1'b0;
      dataA_q    <= '0;
      dataB_q    <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      reqAddr_q  <= reqAddr_d;
      reqData_q  <= reqData_d;
      reqWrite_q <= reqWrite_d;
      cnt_q      <= cnt_d;
      memAddr_q  <= memAddr_d;
      memData_q  <= memData_d;
      memWrite_q <= memWrite_d;
      romEn_q    <= romEn_d;
      ramEn_q    <= ramEn_d;
      fault_q    <= fault_d;
      ackA_q     <= ackA_d;
      ackB_q     <= ackB_d;
      dataA_q    <= dataA_d;
      dataB_q    <= dataB_d;
    end
  end

  assign oAckA     = ackA_q;
  assign oAckB     = ackB_q;
  assign oDataA    = dataA_q;
  assign oDataB    = dataB_q;
  assign oMemAddr  = memAddr_q;
  assign oMemData  = memData_q;
  assign oMemWrite = memWrite_q;
  assign oRomEn    = romEn_q;
  assign oRamEn    = ramEn_q;
  assign oFault    = fault_q;
  assign oBusy     = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_eprisc_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_eprisc_bus_arbiter
//  Purpose  : Directed self-checking bench for eprisc_bus_arbiter. Two
//             instances: u_dut1 (pWaitCycles=1) for the main scenarios and
//             u_dut4 (pWaitCycles=4) for the long-latency read. The memory
//             model only presents valid read data once the address has been
//             held for the full wait time, so early capture is visible.
//  Revision : 1.0  initial release
// ============================================================================
module tb_eprisc_bus_arbiter;

  logic iClk = 1'b0;
  always #5 iClk = ~iClk;

  logic iRst;

  // ---------------- DUT with pWaitCycles = 1 ----------------
  logic        reqA, wrA, reqB, wrB;
  logic [31:0] addrA, dA, addrB, dB;
  logic        ackA1, ackB1, memWr1, romEn1, ramEn1, fault1, busy1;
  logic [31:0] dataA1, dataB1, memAddr1, memData1, memIn1;

  eprisc_bus_arbiter #(.pWaitCycles(1)) u_dut1 (
    .iClk(iClk), .iRst(iRst),
    .iReqA(reqA), .iWriteA(wrA), .iAddrA(addrA), .iDataA(dA),
    .oAckA(ackA1), .oDataA(dataA1),
    .iReqB(reqB), .iWriteB(wrB), .iAddrB(addrB), .iDataB(dB),
    .oAckB(ackB1), .oDataB(dataB1),
    .oMemAddr(memAddr1), .oMemData(memData1), .iMemData(memIn1),
    .oMemWrite(memWr1), .oRomEn(romEn1), .oRamEn(ramEn1),
    .oFault(fault1), .oBusy(busy1)
  );

  // ---------------- DUT with pWaitCycles = 4 ----------------
  logic        reqA4;
  logic [31:0] addrA4;
  logic        ackA4, ackB4, memWr4, romEn4, ramEn4, fault4, busy4;
  logic [31:0] dataA4, dataB4, memAddr4, memData4, memIn4;
  logic        zero1;
  logic [31:0] zero32;
  assign zero1  = 1'b0;
  assign zero32 = 32'h0;

  eprisc_bus_arbiter #(.pWaitCycles(4)) u_dut4 (
    .iClk(iClk), .iRst(iRst),
    .iReqA(reqA4), .iWriteA(zero1), .iAddrA(addrA4), .iDataA(zero32),
    .oAckA(ackA4), .oDataA(dataA4),
    .iReqB(zero1), .iWriteB(zero1), .iAddrB(zero32), .iDataB(zero32),
    .oAckB(ackB4), .oDataB(dataB4),
    .oMemAddr(memAddr4), .oMemData(memData4), .iMemData(memIn4),
    .oMemWrite(memWr4), .oRomEn(romEn4), .oRamEn(ramEn4),
    .oFault(fault4), .oBusy(busy4)
  );

  // ---------------- shared memory model ----------------
  // Writes land whenever oMemWrite is high, regardless of region, so a DUT
  // that strobes a ROM write would corrupt the ROM image.
  logic [31:0] mem [0:511];
  int lat1, lat4;

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 32'hA5000000 | i;
    mem[2] = 32'h08310000;
    mem[3] = 32'h00000333;
  end

  always @(posedge iClk) begin
    if (memWr1) mem[memAddr1[8:0]] <= memData1;
  end

  always @(posedge iClk) begin
    if (iRst || !(romEn1 || ramEn1)) lat1 <= 0; else lat1 <= lat1 + 1;
    if (iRst || !(romEn4 || ramEn4)) lat4 <= 0; else lat4 <= lat4 + 1;
  end

  assign memIn1 = (lat1 >= 1) ? mem[memAddr1[8:0]] : 32'hBAD0BAD0;
  assign memIn4 = (lat4 >= 4) ? mem[memAddr4[8:0]] : 32'hBAD0BAD0;

  bit both_seen = 1'b0;
  always @(negedge iClk) if (ackA1 && ackB1) both_seen = 1'b1;

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge iClk);
    #1;
  endtask

  // One transaction on u_dut1, launched from an IDLE cycle. Returns the
  // number of edges until the ack is seen plus per-signal cycle counts.
  task automatic txn(input bit p, input logic wr, input logic [31:0] a, input logic [31:0] d,
                     output int lat, output int rom, output int ram, output int wrc,
                     output int flt, output logic [31:0] wa);
    if (!p) begin reqA = 1'b1; wrA = wr; addrA = a; dA = d; end
    else    begin reqB = 1'b1; wrB = wr; addrB = a; dB = d; end
    lat = 0; rom = 0; ram = 0; wrc = 0; flt = 0; wa = 32'h0;
    for (int i = 0; i < 40; i++) begin
      tick;
      lat++;
      if (romEn1) rom++;
      if (ramEn1) ram++;
      if (memWr1) begin wrc++; wa = memAddr1; end
      if (fault1) flt++;
      if ((!p && ackA1) || (p && ackB1)) break;
    end
    if (!p) reqA = 1'b0; else reqB = 1'b0;
  endtask

  task automatic rd4(input logic [31:0] a, output int lat, output int en);
    reqA4 = 1'b1; addrA4 = a;
    lat = 0; en = 0;
    for (int i = 0; i < 40; i++) begin
      tick;
      lat++;
      if (romEn4 || ramEn4) en++;
      if (ackA4) break;
    end
    reqA4 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int lat, rom, ram, wrc, flt, nack;
  logic [31:0] wa;
  logic [3:0]  order;
  int          n;

  initial begin
    iRst = 1'b1;
    reqA = 0; wrA = 0; addrA = 0; dA = 0;
    reqB = 0; wrB = 0; addrB = 0; dB = 0;
    reqA4 = 0; addrA4 = 0;
    tick; tick;

    // Reset state
    check("rst_ack",   {30'd0, ackA1, ackB1}, 32'h0);
    check("rst_strb",  {28'd0, romEn1, ramEn1, memWr1, fault1}, 32'h0);
    check("rst_busy",  {31'd0, busy1}, 32'h0);
    check("rst_addr",  memAddr1, 32'h0);
    check("rst_dataA", dataA1, 32'h0);
    check("rst_dataB", dataB1, 32'h0);
    iRst = 1'b0;

    // Read A from ROM[2]
    txn(1'b0, 1'b0, 32'h2, 32'h0, lat, rom, ram, wrc, flt, wa);
    check("rdA_lat",   lat, 3);
    check("rdA_rom",   rom, 2);
    check("rdA_ram",   ram, 0);
    check("rdA_we",    wrc, 0);
    check("rdA_data",  dataA1, 32'h08310000);
    check("rdA_busy",  {31'd0, busy1}, 32'h1);
    check("rdA_hold",  memAddr1, 32'h2);
    tick;
    check("idle_busy", {31'd0, busy1}, 32'h0);

    // Write B to RAM, then read it back
    txn(1'b1, 1'b1, 32'h105, 32'hDEADBEEF, lat, rom, ram, wrc, flt, wa);
    check("wrB_lat",   lat, 2);
    check("wrB_ram",   ram, 1);
    check("wrB_we",    wrc, 1);
    check("wrB_addr",  wa, 32'h105);
    check("wrB_flt",   flt, 0);
    check("wrB_keepA", dataA1, 32'h08310000);
    check("wrB_keepB", dataB1, 32'h0);
    tick;
    txn(1'b1, 1'b0, 32'h105, 32'h0, lat, rom, ram, wrc, flt, wa);
    check("rdB_lat",   lat, 3);
    check("rdB_ram",   ram, 2);
    check("rdB_data",  dataB1, 32'hDEADBEEF);
    tick;

    // ROM write from A: discarded, flagged, acknowledged
    txn(1'b0, 1'b1, 32'h3, 32'h12345678, lat, rom, ram, wrc, flt, wa);
    check("rw_lat",    lat, 2);
    check("rw_flt",    flt, 1);
    check("rw_we",     wrc, 0);
    check("rw_en",     rom + ram, 0);
    check("rw_keepA",  dataA1, 32'h08310000);
    tick;
    txn(1'b0, 1'b0, 32'h3, 32'h0, lat, rom, ram, wrc, flt, wa);
    check("rom3_data", dataA1, 32'h00000333);
    tick;

    // Reset pulsed during WAIT aborts the read
    reqA = 1'b1; wrA = 1'b0; addrA = 32'h105;
    tick;                 // SETUP
    tick;                 // WAIT
    check("rw_inwait", {31'd0, ramEn1}, 32'h1);
    iRst = 1'b1; reqA = 1'b0;
    tick;
    check("abort_ack",  {30'd0, ackA1, ackB1}, 32'h0);
    check("abort_strb", {28'd0, romEn1, ramEn1, memWr1, fault1}, 32'h0);
    check("abort_busy", {31'd0, busy1}, 32'h0);
    check("abort_addr", memAddr1, 32'h0);
    check("abort_data", dataA1, 32'h0);
    iRst = 1'b0;
    nack = 0;
    for (int i = 0; i < 3; i++) begin
      tick;
      if (ackA1 || ackB1) nack++;
    end
    check("abort_noack", nack, 0);
    txn(1'b0, 1'b0, 32'h2, 32'h0, lat, rom, ram, wrc, flt, wa);
    check("fresh_lat",  lat, 3);
    check("fresh_data", dataA1, 32'h08310000);
    tick;

    // Contention after reset: A,B,A,B
    iRst = 1'b1; tick; iRst = 1'b0;
    both_seen = 1'b0;
    reqA = 1'b1; wrA = 1'b0; addrA = 32'h2;
    reqB = 1'b1; wrB = 1'b0; addrB = 32'h105;
    order = 4'h0; n = 0;
    for (int i = 0; i < 60; i++) begin
      tick;
      if (ackA1 || ackB1) begin
        order[n] = ackB1;
        n++;
        if (n == 4) break;
      end
    end
    reqA = 1'b0; reqB = 1'b0;
    check("cont_n",     n, 4);
    check("cont_order", {28'd0, order}, 32'hA);
    check("cont_both",  {31'd0, both_seen}, 32'h0);
    check("cont_dataA", dataA1, 32'h08310000);
    check("cont_dataB", dataB1, 32'hDEADBEEF);
    tick;

    // pWaitCycles = 4 reads
    rd4(32'h105, lat, n);
    check("w4_lat",   lat, 6);
    check("w4_en",    n, 5);
    check("w4_data",  dataA4, 32'hDEADBEEF);
    tick;
    rd4(32'h2, lat, n);
    check("w4_lat2",  lat, 6);
    check("w4_data2", dataA4, 32'h08310000);
    tick;
    check("w4_idle",  {29'd0, romEn4, ramEn4, busy4}, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/eprisc_bus_arbiter.md
EPRISC_BUS_ARBITER -- requirements
Module: eprisc_bus_arbiter

Interface
REQ-001 SHALL have parameter: pWaitCycles, 1, memory read latency in clocks from the address cycle to data valid, range 1..15.
REQ-002 SHALL have ports in this order, one per line below:
  - iClk  in  1  clock; all state changes on the rising edge.
  - iRst  in  1  reset; synchronous, active-high.
  - iReqA  in  1  port A (core) transaction request.
  - iWriteA  in  1  port A: 1 = write, 0 = read.
  - iAddrA  in  32  port A address.
  - iDataA  in  32  port A write data.
  - oAckA  out  1  port A completion pulse.
  - oDataA  out  32  port A read data.
  - iReqB, iWriteB, iAddrB, iDataB, oAckB, oDataB  same widths and meanings for port B (DMA/debug).
  - oMemAddr  out  32  shared bus address.
  - oMemData  out  32  shared bus write data.
  - iMemData  in  32  shared bus read data.
  - oMemWrite  out  1  shared bus write strobe.
  - oRomEn  out  1  ROM select.
  - oRamEn  out  1  RAM select.
  - oFault  out  1  pulse on an illegal ROM write.
  - oBusy  out  1  high whenever the FSM is not in IDLE.

Function
REQ-003 SHALL implement an FSM with states IDLE, SETUP, WAIT and ACK.
REQ-004 IDLE: if any request is high, SHALL grant one port, latch its address, write data, write flag and owner ID, then go to SETUP; otherwise stay in IDLE.
REQ-005 Arbitration SHALL be round-robin: with both requests high, the port not served last wins; with a single request, that port wins.
REQ-006 SETUP (one cycle) SHALL drive oMemAddr and oMemData from the latched values, and decode the region: latched addr[8]=0 is ROM, 1 is RAM.
REQ-007 SETUP read: SHALL assert the region enable (oRomEn or oRamEn), keep oMemWrite=0, load the wait counter with pWaitCycles-1, and go to WAIT.
REQ-008 SETUP RAM write: SHALL assert oRamEn and oMemWrite for this cycle only, then go to ACK.
REQ-009 SETUP ROM write: SHALL keep oRomEn=0 and oMemWrite=0, pulse oFault for one cycle, then go to ACK. The write is discarded but still acknowledged.
REQ-010 WAIT: SHALL hold the enable and address.
  - When the counter is 0: capture iMemData into the owner's oData register and go to ACK.
  - Otherwise: decrement the counter.
REQ-011 ACK (one cycle) SHALL pulse the owner's oAck, record the owner as last-served, and go to IDLE.
  - Enables and oMemWrite SHALL be low in ACK.
REQ-012 oDataA and oDataB SHALL each hold their value until the next completed read for that port; writes SHALL leave them unchanged.
REQ-013 Latency: a request sampled in IDLE at edge N SHALL produce oAck high during the cycle after edge N+2+pWaitCycles for a read, and after edge N+2 for a write.
REQ-014 Requester protocol: a requester holds its request and inputs until it sees oAck, and drops the request in the next cycle.
  - A request still high in IDLE SHALL be treated as a new transaction.
REQ-015 A request dropped before ack SHALL NOT abort the transaction; the ack SHALL still pulse.
REQ-016 Request changes on the non-owner port during a transaction SHALL be ignored until IDLE.
REQ-017 Outside SETUP and WAIT: oMemWrite, oRomEn and oRamEn SHALL be 0; oMemAddr and oMemData SHALL hold their last values.

Reset
REQ-018 With iRst high at a clock edge, the block SHALL:
  - enter IDLE;
  - clear all outputs, oDataA/oDataB and the counter to 0;
  - set last-served to B, so A wins the first tie.
REQ-019 Reset during SETUP, WAIT or ACK SHALL abort the transaction with no ack, fault or data update.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
  - Read A, pWaitCycles=1: iReqA=1, iAddrA=0x02, ROM[2]=0x08310000 -> oRomEn high for 2 cycles; oAckA pulses at edge N+3; oDataA=0x08310000.
  - Write B to RAM: iReqB=1, iWriteB=1, iAddrB=0x105, iDataB=0xDEADBEEF -> oRamEn=oMemWrite=1 for one cycle with oMemAddr=0x105; oAckB at N+2; a following read of 0x105 returns 0xDEADBEEF.
  - Contention: iReqA=iReqB=1, held and re-raised after each ack -> grant order A,B,A,B after reset; no cycle with both acks high.
  - ROM write: iWriteA=1, iAddrA=0x003 -> oFault pulses once; oMemWrite stays 0; oAckA at N+2; ROM contents unchanged.
  - pWaitCycles=4 read -> oAck exactly 6 cycles after the request edge; read data captured on the last WAIT cycle.
  - iRst pulsed during WAIT -> no oAck; all outputs 0 next cycle; a fresh request completes normally.
